// File: rtl/mod_n_step_counter.sv
// Modulo-N counter with hold/+1/+2/-1 step modes, parallel load and
// registered wrap/borrow/load-error strobes for cascading digits.
module mod_n_step_counter #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Count,
    output logic             Wrap,
    output logic             Borrow,
    output logic             LoadErr,
    output logic             AtMax
);

    if (MODULUS < 3) begin : g_bad_modulus
        $error("mod_n_step_counter: MODULUS must be at least 3");
    end
    if ((1 << WIDTH) < MODULUS) begin : g_bad_width
        $error("mod_n_step_counter: WIDTH too small for MODULUS");
    end

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_INC1 = 2'b01,
        MODE_INC2 = 2'b10,
        MODE_DEC  = 2'b11
    } mode_e;

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             borrow_q, borrow_d;
    logic             lerr_q, lerr_d;

    logic [WIDTH:0]   sum;
    logic             in_range;
    logic             load_ok;
    mode_e            mode;

    assign mode     = mode_e'(Mode);
    // One spare bit so Count + 2 never overflows when MODULUS == 2**WIDTH.
    assign sum      = {1'b0, count_q}
                    + ((mode == MODE_INC2) ? (WIDTH+1)'(2)
                                           : (WIDTH+1)'(1));
    assign in_range = ({1'b0, count_q} < MOD_W);
    assign load_ok  = ({1'b0, LoadValue} < MOD_W);

    always_comb begin
        count_d  = count_q;
        wrap_d   = 1'b0;
        borrow_d = 1'b0;
        lerr_d   = 1'b0;
        if (Load) begin
            if (load_ok) begin
                count_d = LoadValue;
            end else begin
                count_d = '0;
                lerr_d  = 1'b1;
            end
        end else if (!in_range) begin
            count_d = '0;
        end else if (En) begin
            unique case (mode)
                MODE_HOLD: count_d = count_q;
                MODE_INC1,
                MODE_INC2: begin
                    if (sum >= MOD_W) begin
                        count_d = WIDTH'(sum - MOD_W);
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = sum[WIDTH-1:0];
                    end
                end
                MODE_DEC: begin
                    if (count_q == '0) begin
                        count_d  = MAX_V;
                        borrow_d = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q  <= '0;
            wrap_q   <= 1'b0;
            borrow_q <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            wrap_q   <= wrap_d;
            borrow_q <= borrow_d;
            lerr_q   <= lerr_d;
        end
    end

    assign Count   = count_q;
    assign Wrap    = wrap_q;
    assign Borrow  = borrow_q;
    assign LoadErr = lerr_q;
    assign AtMax   = (count_q == MAX_V);

endmodule

// File: tb/tb_mod_n_step_counter.sv
// Bench for mod_n_step_counter: mod-10, mod-16 and a cascaded upper digit
// checked every cycle against an integer-arithmetic reference model.
module tb_mod_n_step_counter;

    logic       Clock = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       ld = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [3:0] c10, c16, chi;
    logic       w10, b10, e10, a10;
    logic       w16, b16, e16, a16;
    logic       whi, bhi, ehi, ahi;
    logic       hi_en;

    assign hi_en = w10 | b10;

    always #5 Clock = ~Clock;

    mod_n_step_counter #(.MODULUS(10), .WIDTH(4)) u10 (
        .Clock(Clock), .Reset(rst), .En(en), .Mode(mode), .Load(ld),
        .LoadValue(lv), .Count(c10), .Wrap(w10), .Borrow(b10),
        .LoadErr(e10), .AtMax(a10));

    mod_n_step_counter #(.MODULUS(16), .WIDTH(4)) u16 (
        .Clock(Clock), .Reset(rst), .En(en), .Mode(mode), .Load(ld),
        .LoadValue(lv), .Count(c16), .Wrap(w16), .Borrow(b16),
        .LoadErr(e16), .AtMax(a16));

    mod_n_step_counter #(.MODULUS(10), .WIDTH(4)) uhi (
        .Clock(Clock), .Reset(rst), .En(hi_en), .Mode(mode), .Load(ld),
        .LoadValue(lv), .Count(chi), .Wrap(whi), .Borrow(bhi),
        .LoadErr(ehi), .AtMax(ahi));

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    int m10c = 0, m16c = 0, mhic = 0;
    bit m10w, m10b, m10e, m16w, m16b, m16e, mhiw, mhib, mhie;

    function automatic void chk(string nm, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    task automatic mstep(input int md, input bit r, input bit l,
                         input bit e, input bit [1:0] m, input int v,
                         inout int c, inout bit w, inout bit b,
                         inout bit le);
        int n;
        w = 0; b = 0; le = 0;
        if (r) c = 0;
        else if (l) begin
            if (v < md) c = v;
            else begin c = 0; le = 1; end
        end else if (c >= md) c = 0;
        else if (e && m != 2'b00) begin
            n = c + ((m == 2'b11) ? -1 : int'(m));
            if (n >= md) begin n -= md; w = 1; end
            else if (n < 0) begin n += md; b = 1; end
            c = n;
        end
    endtask

    always @(posedge Clock) begin
        bit hen;
        hen = m10w | m10b;
        mstep(10, rst, ld, hen, mode, int'(lv), mhic, mhiw, mhib, mhie);
        mstep(10, rst, ld, en, mode, int'(lv), m10c, m10w, m10b, m10e);
        mstep(16, rst, ld, en, mode, int'(lv), m16c, m16w, m16b, m16e);
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            chk("u10.Count", int'(c10), m10c);
            chk("u10.Wrap", int'(w10), int'(m10w));
            chk("u10.Borrow", int'(b10), int'(m10b));
            chk("u10.LoadErr", int'(e10), int'(m10e));
            chk("u10.AtMax", int'(a10), int'(m10c == 9));
            chk("u16.Count", int'(c16), m16c);
            chk("u16.Wrap", int'(w16), int'(m16w));
            chk("u16.Borrow", int'(b16), int'(m16b));
            chk("u16.LoadErr", int'(e16), int'(m16e));
            chk("u16.AtMax", int'(a16), int'(m16c == 15));
            chk("uhi.Count", int'(chi), mhic);
            chk("uhi.Wrap", int'(whi), int'(mhiw));
            chk("uhi.Borrow", int'(bhi), int'(mhib));
            chk("uhi.LoadErr", int'(ehi), int'(mhie));
        end
    end

    task automatic cyc(input bit r, input bit e, input bit [1:0] m,
                       input bit l, input int v);
        #1;
        rst = r; en = e; mode = m; ld = l; lv = 4'(v);
        @(negedge Clock);
    endtask

    initial begin
        int ev[4];
        int wv[4];
        // Reset, then +1 for 12 cycles
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst.Count", int'(c10), 0);
        chk("rst.Strobes", int'({w10, b10, e10}), 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 1, 2'b01, 0, 0);
            chk("t1.Count", int'(c10), (i + 1) % 10);
            chk("t1.Wrap", int'(w10), int'(i == 9));
        end
        // Load 7 then +2 x4, then out-of-range load
        cyc(0, 0, 0, 1, 7);
        chk("t2.Load7", int'(c10), 7);
        ev = '{9, 1, 3, 5};
        wv = '{0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 2'b10, 0, 0);
            chk("t2.Count", int'(c10), ev[i]);
            chk("t2.Wrap", int'(w10), wv[i]);
        end
        cyc(0, 1, 2'b01, 1, 15);
        chk("t2.Load15.Count", int'(c10), 0);
        chk("t2.Load15.Err", int'(e10), 1);
        chk("t2.Load15.Wrap", int'(w10), 0);
        chk("t2.u16.Load15", int'(c16), 15);
        chk("t2.u16.NoErr", int'(e16), 0);
        cyc(0, 0, 2'b01, 0, 0);
        chk("t2.ErrDrop", int'(e10), 0);
        // Down steps, then frozen
        cyc(0, 0, 0, 1, 0);
        ev = '{9, 8, 7, 7};
        wv = '{1, 0, 0, 0};
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 2'b11, 0, 0);
            chk("t3.Count", int'(c10), ev[i]);
            chk("t3.Borrow", int'(b10), wv[i]);
        end
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) cyc(0, 0, 2'b01, 0, 0);
            else cyc(0, 1, 2'b00, 0, 0);
            chk("t3.Frozen", int'(c10), 7);
            chk("t3.NoStrobe", int'({w10, b10, e10}), 0);
        end
        // Priority
        cyc(0, 1, 2'b01, 1, 4);
        chk("t4.LoadWins", int'(c10), 4);
        cyc(1, 1, 2'b01, 1, 9);
        chk("t4.ResetWins", int'(c10), 0);
        chk("t4.ResetStrobes", int'({w10, b10, e10}), 0);
        // Full-power-of-two modulus
        cyc(0, 0, 0, 1, 15);
        cyc(0, 1, 2'b01, 0, 0);
        chk("t5.15p1", int'(c16), 0);
        chk("t5.15p1.Wrap", int'(w16), 1);
        cyc(0, 0, 0, 1, 14);
        cyc(0, 1, 2'b10, 0, 0);
        chk("t5.14p2", int'(c16), 0);
        chk("t5.14p2.Wrap", int'(w16), 1);
        cyc(0, 0, 0, 1, 15);
        cyc(0, 1, 2'b10, 0, 0);
        chk("t5.15p2", int'(c16), 1);
        chk("t5.15p2.Wrap", int'(w16), 1);
        // Cascade 99 -> 00 -> 99
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 9);
        cyc(0, 1, 2'b01, 0, 0);
        cyc(0, 0, 2'b01, 0, 0);
        chk("t6.Up.Hi", int'(chi), 0);
        chk("t6.Up.Lo", int'(c10), 0);
        cyc(0, 1, 2'b11, 0, 0);
        cyc(0, 0, 2'b11, 0, 0);
        chk("t6.Dn.Hi", int'(chi), 9);
        chk("t6.Dn.Lo", int'(c10), 9);
        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 3) != 0,
                2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 15)));
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
